// File: rtl/match_game_core.sv
// match_game_core: round controller for the switch-matching reaction game.
// Holds CHANNELS LFSR-drawn target symbols, compares them with the player's
// guesses, and keeps a BCD elapsed-seconds timer and a saturating BCD score.
module match_game_core #(
    parameter int          CHANNELS      = 3,
    parameter int          SYM_W         = 2,
    parameter int          NUM_SYMBOLS   = 3,
    parameter int          TICKS_PER_SEC = 50_000_000,
    parameter int          ROUND_SECS    = 60,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      submit,
    input  logic [CHANNELS*SYM_W-1:0] guess,
    output logic [CHANNELS*SYM_W-1:0] target,
    output logic [CHANNELS-1:0]       match,
    output logic [3:0]                secs_ones,
    output logic [3:0]                secs_tens,
    output logic [3:0]                score_ones,
    output logic [3:0]                score_tens,
    output logic                      playing,
    output logic                      game_over,
    output logic                      tick
);

    localparam int              IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int              PRE_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]      END_ONES = 4'(ROUND_SECS % 10);
    localparam logic [3:0]      END_TENS = 4'(ROUND_SECS / 10);
    localparam logic [7:0]      NSYM     = 8'(NUM_SYMBOLS);
    localparam logic [15:0]     TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        OVER
    } state_t;

    state_t               state;
    logic [15:0]          lfsr;
    logic [IDX_W-1:0]     idx;
    logic [PRE_W-1:0]     prescale;
    logic [CHANNELS-1:0]  match_next;
    logic [SYM_W-1:0]     new_sym;
    logic                 pre_wrap;
    logic                 final_sec;
    logic                 score_full;
    logic [3:0]           secs_ones_next;
    logic [3:0]           secs_tens_next;
    logic [3:0]           score_ones_next;
    logic [3:0]           score_tens_next;

    // Free-running Galois LFSR; shifts every cycle in every state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lfsr <= SEED;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        end
    end

    // Per-channel comparison, only meaningful while a round is live.
    always_comb begin
        match_next = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            match_next[i] = (guess[i*SYM_W +: SYM_W] == target[i*SYM_W +: SYM_W]) &&
                            (state == PLAY);
        end
    end

    // Registered match flags.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            match <= '0;
        end else begin
            match <= match_next;
        end
    end

    // Next symbol, BCD increments, and end-of-round detection.
    always_comb begin
        new_sym  = SYM_W'(lfsr[7:0] % NSYM);
        pre_wrap = (prescale == LAST_PRE);

        if (secs_ones == 4'd9) begin
            secs_ones_next = 4'd0;
            secs_tens_next = secs_tens + 4'd1;
        end else begin
            secs_ones_next = secs_ones + 4'd1;
            secs_tens_next = secs_tens;
        end
        final_sec = pre_wrap && (secs_ones_next == END_ONES) && (secs_tens_next == END_TENS);

        if (score_ones == 4'd9) begin
            score_ones_next = 4'd0;
            score_tens_next = score_tens + 4'd1;
        end else begin
            score_ones_next = score_ones + 4'd1;
            score_tens_next = score_tens;
        end
        score_full = (score_ones == 4'd9) && (score_tens == 4'd9);
    end

    // Game state machine: target loading, timer, score, and status outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            prescale   <= '0;
            target     <= '0;
            secs_ones  <= '0;
            secs_tens  <= '0;
            score_ones <= '0;
            score_tens <= '0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        score_ones <= '0;
                        score_tens <= '0;
                        secs_ones  <= '0;
                        secs_tens  <= '0;
                        prescale   <= '0;
                        idx        <= '0;
                        playing    <= 1'b0;
                        game_over  <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    target[idx*SYM_W +: SYM_W] <= new_sym;
                    if (idx == LAST_IDX) begin
                        playing <= 1'b1;
                        state   <= PLAY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PLAY: begin
                    prescale <= pre_wrap ? '0 : prescale + 1'b1;
                    if (pre_wrap) begin
                        tick      <= 1'b1;
                        secs_ones <= secs_ones_next;
                        secs_tens <= secs_tens_next;
                    end
                    // The final tick takes priority over a simultaneous submit.
                    if (final_sec) begin
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (submit && (&match)) begin
                        if (!score_full) begin
                            score_ones <= score_ones_next;
                            score_tens <= score_tens_next;
                        end
                        idx     <= '0;
                        playing <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_game_core.sv
// tb_match_game_core: directed and randomized checks of match_game_core
// against an integer-arithmetic reference model of the game rules.
module tb_match_game_core;

    localparam int          CH   = 3;
    localparam int          SW   = 2;
    localparam int          NS   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn_a, start_a, submit_a, playing_a, over_a, tick_a;
    logic [CH*SW-1:0] guess_a, target_a;
    logic [CH-1:0]    match_a;
    logic [3:0]       so_a, st_a, co_a, ct_a;

    logic             resetn_b, start_b, submit_b, playing_b, over_b, tick_b;
    logic [CH*SW-1:0] guess_b, target_b;
    logic [CH-1:0]    match_b;
    logic [3:0]       so_b, st_b, co_b, ct_b;

    match_game_core #(
        .CHANNELS(CH), .SYM_W(SW), .NUM_SYMBOLS(NS),
        .TICKS_PER_SEC(4), .ROUND_SECS(3), .SEED(SEED)
    ) dut_a (
        .CLOCK_50(clk), .resetn(resetn_a), .start(start_a), .submit(submit_a),
        .guess(guess_a), .target(target_a), .match(match_a),
        .secs_ones(so_a), .secs_tens(st_a), .score_ones(co_a), .score_tens(ct_a),
        .playing(playing_a), .game_over(over_a), .tick(tick_a)
    );

    match_game_core #(
        .CHANNELS(CH), .SYM_W(SW), .NUM_SYMBOLS(NS),
        .TICKS_PER_SEC(16), .ROUND_SECS(99), .SEED(SEED)
    ) dut_b (
        .CLOCK_50(clk), .resetn(resetn_b), .start(start_b), .submit(submit_b),
        .guess(guess_b), .target(target_b), .match(match_b),
        .secs_ones(so_b), .secs_tens(st_b), .score_ones(co_b), .score_tens(ct_b),
        .playing(playing_b), .game_over(over_b), .tick(tick_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model, one slot per DUT instance.
    int          m_ticks [2] = '{4, 16};
    int          m_rsecs [2] = '{3, 99};
    logic [15:0] m_lfsr  [2];
    int          m_target[2][CH];
    int          m_match [2];
    int          m_secs  [2];
    int          m_score [2];
    int          m_pre   [2];
    int          m_load  [2];
    bit          m_play  [2];
    bit          m_over  [2];
    bit          m_tick  [2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [CH*SW-1:0] model_guess(input int i);
        logic [CH*SW-1:0] g;
        g = '0;
        for (int c = 0; c < CH; c++) g[c*SW +: SW] = SW'(m_target[i][c]);
        return g;
    endfunction

    task automatic model_reset(input int i);
        m_lfsr[i] = SEED;
        for (int c = 0; c < CH; c++) m_target[i][c] = 0;
        m_match[i] = 0; m_secs[i] = 0; m_score[i] = 0; m_pre[i] = 0;
        m_load[i] = 0; m_play[i] = 0; m_over[i] = 0; m_tick[i] = 0;
    endtask

    task automatic model_edge(input int i, input logic st, input logic sb,
                              input logic [CH*SW-1:0] g);
        int          new_match;
        logic [15:0] cur;
        bit          final_tick;
        new_match  = 0;
        final_tick = 0;
        if (m_play[i])
            for (int c = 0; c < CH; c++)
                if (int'(g[c*SW +: SW]) == m_target[i][c]) new_match |= (1 << c);
        cur       = m_lfsr[i];
        m_tick[i] = 0;
        if (m_load[i] > 0) begin
            m_target[i][CH - m_load[i]] = int'(cur[7:0]) % NS;
            m_load[i]--;
            if (m_load[i] == 0) m_play[i] = 1;
        end else if (m_play[i]) begin
            m_pre[i]++;
            if (m_pre[i] == m_ticks[i]) begin
                m_pre[i]  = 0;
                m_tick[i] = 1;
                m_secs[i]++;
                if (m_secs[i] == m_rsecs[i]) final_tick = 1;
            end
            if (final_tick) begin
                m_play[i] = 0;
                m_over[i] = 1;
            end else if (sb && m_match[i] == (1 << CH) - 1) begin
                if (m_score[i] < 99) m_score[i]++;
                m_play[i] = 0;
                m_load[i] = CH;
            end
        end else if (st) begin
            m_score[i] = 0; m_secs[i] = 0; m_pre[i] = 0;
            m_over[i]  = 0; m_load[i] = CH;
        end
        m_match[i] = new_match;
        m_lfsr[i]  = lfsr_next(cur);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int i);
        logic [CH*SW-1:0] t;
        logic [CH-1:0]    m;
        logic [3:0]       so, st, co, ct;
        logic             p, o, tk;
        string            n;
        if (i == 0) begin
            n = "a"; t = target_a; m = match_a; so = so_a; st = st_a; co = co_a; ct = ct_a;
            p = playing_a; o = over_a; tk = tick_a;
        end else begin
            n = "b"; t = target_b; m = match_b; so = so_b; st = st_b; co = co_b; ct = ct_b;
            p = playing_b; o = over_b; tk = tick_b;
        end
        check({n, ".target"},     32'(t),  32'(model_guess(i)));
        check({n, ".match"},      32'(m),  m_match[i]);
        check({n, ".secs_ones"},  32'(so), m_secs[i] % 10);
        check({n, ".secs_tens"},  32'(st), m_secs[i] / 10);
        check({n, ".score_ones"}, 32'(co), m_score[i] % 10);
        check({n, ".score_tens"}, 32'(ct), m_score[i] / 10);
        check({n, ".playing"},    32'(p),  32'(m_play[i]));
        check({n, ".game_over"},  32'(o),  32'(m_over[i]));
        check({n, ".tick"},       32'(tk), 32'(m_tick[i]));
    endtask

    // One clock: drive pulses from the falling edge, model the rising edge,
    // then compare on the next falling edge.
    task automatic step(input logic sa, input logic sba, input logic sbs, input logic sbb);
        start_a = sa; submit_a = sba; start_b = sbs; submit_b = sbb;
        @(posedge clk);
        if (resetn_a) model_edge(0, sa, sba, guess_a);
        if (resetn_b) model_edge(1, sbs, sbb, guess_b);
        @(negedge clk);
        start_a = 1'b0; submit_a = 1'b0; start_b = 1'b0; submit_b = 1'b0;
        check_all(0);
        check_all(1);
    endtask

    initial begin
        logic [CH*SW-1:0] g;
        logic             sub;

        resetn_a = 1'b0; resetn_b = 1'b0;
        start_a = 1'b0; submit_a = 1'b0; guess_a = '0;
        start_b = 1'b0; submit_b = 1'b0; guess_b = '0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check_all(0);
        check_all(1);
        resetn_a = 1'b1; resetn_b = 1'b1;

        // Idle after reset.
        repeat (10) step(0, 0, 0, 0);
        check("a.idle_playing", 32'(playing_a), 0);

        // Start: three LOAD cycles, PLAY on the fourth.
        step(1, 0, 0, 0); check("a.load1_playing", 32'(playing_a), 0);
        step(0, 0, 0, 0); check("a.load2_playing", 32'(playing_a), 0);
        step(0, 0, 0, 0); check("a.load3_playing", 32'(playing_a), 0);
        step(0, 0, 0, 0); check("a.play_after_load", 32'(playing_a), 1);
        for (int c = 0; c < CH; c++)
            check("a.target_range", 32'(target_a[c*SW +: SW] < SW'(NS)), 1);

        // Correct guess and submit.
        guess_a = model_guess(0);
        step(0, 0, 0, 0); check("a.match_all", 32'(match_a), 32'h7);
        step(0, 1, 0, 0);
        check("a.score_after_hit", 32'(co_a), 1);
        check("a.reload_playing", 32'(playing_a), 0);
        repeat (3) step(0, 0, 0, 0);
        check("a.replay", 32'(playing_a), 1);

        // One channel wrong.
        g = model_guess(0);
        g[1*SW +: SW] = SW'((m_target[0][1] + 1) % NS);
        guess_a = g;
        step(0, 0, 0, 0); check("a.match_partial", 32'(match_a), 32'h5);
        step(0, 1, 0, 0);
        check("a.miss_score", 32'(co_a), 1);
        check("a.miss_stays_play", 32'(playing_a), 1);

        // Run out the round, then submit in OVER.
        for (int n = 0; n < 100 && !m_over[0]; n++) step(0, 0, 0, 0);
        check("a.timeout_over", 32'(over_a), 1);
        check("a.timeout_secs", 32'(so_a), 3);
        step(0, 1, 0, 0);
        check("a.over_submit_score", 32'(co_a), 1);
        check("a.over_submit_state", 32'(over_a), 1);

        // Submit coincident with the final tick.
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        guess_a = model_guess(0);
        for (int n = 0; n < 100 && !(m_play[0] && m_secs[0] == 2 && m_pre[0] == 3); n++)
            step(0, 0, 0, 0);
        check("a.pre_final_match", 32'(match_a), 32'h7);
        step(0, 1, 0, 0);
        check("a.final_over", 32'(over_a), 1);
        check("a.final_tick", 32'(tick_a), 1);
        check("a.final_score", 32'(co_a), 0);
        check("a.final_playing", 32'(playing_a), 0);

        // start and submit together in OVER.
        step(1, 1, 0, 0);
        check("a.start_wins_over", 32'(over_a), 0);
        check("a.start_wins_play", 32'(playing_a), 0);

        // Randomized play.
        for (int n = 0; n < 400; n++) begin
            guess_a = ($urandom_range(0, 1) == 1) ? model_guess(0) : CH*SW'($urandom_range(0, 63));
            step(($urandom_range(0, 3) == 0) || m_over[0], $urandom_range(0, 2) == 0, 0, 0);
        end

        // Instance b: drive score to the 99 ceiling.
        step(0, 0, 1, 0);
        for (int n = 0; n < 3000 && m_score[1] < 99; n++) begin
            guess_b = model_guess(1);
            step(0, 0, 0, (m_play[1] && m_match[1] == 7) ? 1'b1 : 1'b0);
        end
        check("b.score_99_tens", 32'(ct_b), 9);
        check("b.score_99_ones", 32'(co_b), 9);
        sub = 1'b0;
        for (int n = 0; n < 20 && !sub; n++) begin
            guess_b = model_guess(1);
            sub = (m_play[1] && m_match[1] == 7) ? 1'b1 : 1'b0;
            step(0, 0, 0, sub);
        end
        check("b.sat_tens", 32'(ct_b), 9);
        check("b.sat_ones", 32'(co_b), 9);
        check("b.sat_reload", 32'(playing_b), 0);
        repeat (4) step(0, 0, 0, 0);
        check("b.mid_play", 32'(playing_b), 1);

        // Asynchronous reset mid-PLAY.
        #2 resetn_b = 1'b0;
        #1;
        check("b.rst_target", 32'(target_b), 0);
        check("b.rst_match", 32'(match_b), 0);
        check("b.rst_secs", 32'({st_b, so_b}), 0);
        check("b.rst_score", 32'({ct_b, co_b}), 0);
        check("b.rst_flags", 32'({playing_b, over_b, tick_b}), 0);
        model_reset(1);
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
